// File: rtl/confreg_pkg.sv
// Purpose: shared register map, status bit positions and reset values for the
//          configuration responder, plus the byte-enable merge helper.
package confreg_pkg;

    // Register offsets within the 64 KiB region
    localparam logic [15:0] OFF_SCRATCH_LAST = 16'h001C;
    localparam logic [15:0] OFF_LED          = 16'h8000;
    localparam logic [15:0] OFF_SWITCH       = 16'h8004;
    localparam logic [15:0] OFF_TIMER        = 16'h8008;
    localparam logic [15:0] OFF_UART_TX      = 16'h800C;
    localparam logic [15:0] OFF_UART_STAT    = 16'h8010;
    localparam logic [15:0] OFF_NUM          = 16'h8014;

    // UART_STAT field positions
    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_CNT_LSB   = 8;

    localparam logic [15:0] LED_RST = 16'hFFFF;

    // Replace only the bytes whose enable is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock circular-buffer FIFO with occupancy count.
// Ports:   i_push/i_push_data  - write request and payload
//          i_pop               - consume head (ignored while empty)
//          o_head_c            - head entry, zero while empty
//          o_full_c/o_empty_c  - occupancy flags
//          o_count             - number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_c,
    output logic                       o_full_c,
    output logic                       o_empty_c,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_count   = r_count;
    assign o_head_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_pop_ok  = i_pop && !o_empty_c;
    assign w_push_ok = i_push && (!o_full_c || w_pop_ok);

    // Storage needs no reset: nothing is visible until the count says so
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/confreg_sram_resp.sv
// Purpose: memory-mapped config/peripheral responder on a data-SRAM style bus
//          with 1-cycle read latency: scratch regs, LED/switch/7-seg regs,
//          free-running timer, and a byte TX FIFO toward a UART.
// Ports:   sram_en/we/addr/wdata - request in;  sram_rdata - read data
//          switch_in             - async board switches
//          led_out, num_out      - LED and seven-segment registers
//          uart_tx_valid/data/ready - TX FIFO head handshake
module confreg_sram_resp
    import confreg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hBFAF_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] TIMER_RST  = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_scratch [8];
    logic [15:0]   r_led;
    logic [31:0]   r_num;
    logic [31:0]   r_timer;
    logic [15:0]   r_sw_meta;
    logic [15:0]   r_sw_sync;
    logic          r_ovf;
    logic [31:0]   r_rdata;

    logic          w_hit;
    logic          w_rd;
    logic          w_wr;
    logic [15:0]   w_off;
    logic          w_is_scratch;
    logic [31:0]   w_rd_val;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [1:0]    w_unused_addr;

    assign w_unused_addr = sram_addr[1:0];

    // Request decode; byte offset bits are dropped so accesses are word-aligned
    assign w_hit        = sram_en && (sram_addr[31:16] == BASE_ADDR[31:16]);
    assign w_off        = {sram_addr[15:2], 2'b00};
    assign w_rd         = sram_en && (sram_we == 4'b0000);
    assign w_wr         = w_hit && (sram_we != 4'b0000);
    assign w_is_scratch = (w_off <= OFF_SCRATCH_LAST);

    // Read mux over pre-edge register values
    always_comb begin
        w_rd_val = '0;
        if (w_hit) begin
            if (w_is_scratch) begin
                w_rd_val = r_scratch[sram_addr[4:2]];
            end else begin
                case (w_off)
                    OFF_LED:       w_rd_val = {16'h0, r_led};
                    OFF_SWITCH:    w_rd_val = {16'h0, r_sw_sync};
                    OFF_TIMER:     w_rd_val = r_timer;
                    OFF_UART_STAT: begin
                        w_rd_val[STAT_FULL_BIT]        = w_full;
                        w_rd_val[STAT_EMPTY_BIT]       = w_empty;
                        w_rd_val[STAT_OVF_BIT]         = r_ovf;
                        w_rd_val[STAT_CNT_LSB +: 8]    = 8'(w_count);
                    end
                    OFF_NUM:       w_rd_val = r_num;
                    default:       w_rd_val = '0;
                endcase
            end
        end
    end

    // TX FIFO control and sticky overflow; a new drop beats a same-cycle clear
    assign w_push    = w_wr && (w_off == OFF_UART_TX) && sram_we[0];
    assign w_pop     = uart_tx_valid && uart_tx_ready;
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_ovf_clr = w_wr && (w_off == OFF_UART_STAT) && sram_we[0] && sram_wdata[STAT_OVF_BIT];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_data (sram_wdata[7:0]),
        .i_pop       (w_pop),
        .o_head_c    (w_head),
        .o_full_c    (w_full),
        .o_empty_c   (w_empty),
        .o_count     (w_count)
    );

    assign uart_tx_valid = !w_empty;
    assign uart_tx_data  = w_head;
    assign sram_rdata    = r_rdata;
    assign led_out       = r_led;
    assign num_out       = r_num;

    // Register file, timer, switch synchronizer and read-data hold register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) r_scratch[i] <= '0;
            r_led     <= LED_RST;
            r_num     <= '0;
            r_timer   <= TIMER_RST;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_ovf     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;

            if (w_rd) r_rdata <= w_rd_val;

            if (w_wr && w_is_scratch) begin
                r_scratch[sram_addr[4:2]] <= byte_merge(r_scratch[sram_addr[4:2]], sram_wdata, sram_we);
            end
            if (w_wr && (w_off == OFF_LED)) begin
                r_led <= 16'(byte_merge({16'h0, r_led}, sram_wdata, sram_we));
            end
            if (w_wr && (w_off == OFF_NUM)) begin
                r_num <= byte_merge(r_num, sram_wdata, sram_we);
            end

            if (w_wr && (w_off == OFF_TIMER)) r_timer <= byte_merge(r_timer, sram_wdata, sram_we);
            else                              r_timer <= r_timer + 32'd1;

            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

endmodule
